// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a req/ack
// handshake into the instruction register and computes the next PC on retire.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   input  logic [31:0] SignImm,
   input  logic        retire,
   input  logic        stall,
   output logic [31:0] Instr,
   output logic [5:0]  Opcode,
   output logic [5:0]  Funct,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        instr_valid
);

   // Memory handshake: imem_req stays high with a stable imem_addr until a cycle
   // in which imem_ack is sampled high; that edge captures imem_rdata.
   typedef enum logic {
      FETCH = 1'b0,
      EXEC  = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC_ALIGNED;
         instr_q <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign pc_plus4   = pc_q + 32'd4;
   assign branch_off = SignImm << 2;

   // Jump outranks Branch; all three sources keep bits [1:0] at zero.
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (retire && !stall) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // The request is gated by rst so it drops in the same cycle reset is applied.
   assign imem_req    = (state_q == FETCH) && !rst;
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == EXEC);
   assign Instr       = instr_q;
   assign Opcode      = instr_q[31:26];
   assign Funct       = instr_q[5:0];
   assign PC          = pc_q;
   assign PCPlus4     = pc_plus4;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multi-cycle instruction fetch stage that sits directly upstream of the control unit and datapath. It holds the program counter and requests instructions from an instruction memory over a req/ack handshake. It latches the returned word into an instruction register and presents Opcode/Funct to the control decoder. It computes the next PC from the Branch/Jump decode, the ALU Zero flag and the sign-extended immediate once the downstream stage signals retirement.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and forced to 2'b00.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  byte address of the requested word; equals PC.
imem_ack  input  1  memory has valid data on imem_rdata this cycle.
imem_rdata  input  32  instruction word returned by memory.
Branch  input  1  branch decode from the control unit.
Jump  input  1  jump decode from the control unit.
Zero  input  1  ALU zero flag.
SignImm  input  32  sign-extended 16-bit immediate.
retire  input  1  downstream stage has finished the current instruction.
stall  input  1  holds the current instruction; blocks retirement.
Instr  output  32  instruction register.
Opcode  output  6  Instr[31:26].
Funct  output  6  Instr[5:0].
PC  output  32  address of the instruction held in Instr.
PCPlus4  output  32  PC + 4.
instr_valid  output  1  Instr holds a fetched, unretired instruction.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC with [1:0]=00, Instr=0, state=FETCH, instr_valid=0.
  - imem_req is forced to 0 while rst=1.
- State machine has two states, FETCH and EXEC.
- FETCH:
  - imem_req=1 and imem_addr=PC; instr_valid=0.
  - On a clock edge with imem_ack=1: Instr<=imem_rdata, state<=EXEC.
  - Ack may arrive in the same cycle req first rises, giving a 1-cycle fetch minimum.
  - Wait states of any length are allowed; req and addr stay stable until ack.
- EXEC:
  - imem_req=0 and instr_valid=1.
  - imem_ack in this state is ignored; Instr is unchanged.
  - On a clock edge with retire=1 and stall=0: PC<=next_pc, state<=FETCH.
  - If retire=1 and stall=1, nothing changes; stall wins.
- next_pc, evaluated combinationally from the current inputs in the retiring cycle:
  - If Jump=1: {PCPlus4[31:28], Instr[25:0], 2'b00}. Jump has priority over Branch.
  - Else if Branch & Zero: PCPlus4 + (SignImm << 2).
  - Otherwise: PCPlus4.
- Arithmetic is 32-bit modulo 2^32, with no overflow flag.
  - 0xFFFF_FFFC + 4 = 0x0000_0000.
  - Backward branches wrap the same way.
- PC[1:0] is always 00; every next_pc source is word-aligned by construction.
- Opcode, Funct and PCPlus4 are combinational from Instr and PC and remain stable throughout EXEC.
- Throughput is at most one instruction per two cycles (one ack cycle plus one retire cycle).
- Reset asserted mid-fetch or mid-EXEC aborts immediately. Any ack already outstanding after reset release is treated as a response to the new RESET_PC request; memory is required to drop ack while rst=1.

Test Plan:
- Reset/sequential: assert rst, then release. imem_req=1 with imem_addr=0x0 on the first cycle. Ack with 0x2009_0005, then retire. PC=0x4 and imem_req=1; Opcode=0x08 during EXEC.
- Wait states: hold ack low for 3 cycles at PC=0x10. imem_req and imem_addr=0x10 stay stable, instr_valid=0. Ack on the 4th cycle gives instr_valid=1 on the next cycle.
- Branch: PC=0x20, Branch=1. With Zero=1 and SignImm=0xFFFF_FFFE, retire gives next PC=0x1C. Repeat with Zero=0 and SignImm=0xFFFF_FFFE: next PC=0x24.
- Jump priority: PC=0x4000_0008, Instr=0x0800_0040, Jump=1, Branch=1, Zero=1. Retire gives PC=0x4000_0100.
- Stall/ignored ack:
  - In EXEC, hold retire=1 with stall=1 for 4 cycles: PC and Instr are unchanged, imem_req=0.
  - Pulse imem_ack with imem_rdata=0xDEAD_BEEF during EXEC: Instr is unchanged.
  - Drop stall: PC advances by 4.
- Wrap and mid-op reset:
  - At PC=0xFFFF_FFFC, a sequential retire gives PC=0x0.
  - Assert rst asynchronously during a FETCH wait: imem_req falls in the same cycle, PC=RESET_PC, instr_valid=0.
